// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage controller: opcodes, FSM states,
// error data pattern and the branch-condition helper.
package mem_stage_ctrl_pkg;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic logic branch_cond(input logic [5:0] opcode, input logic zero);
    return ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register; a stalled MEM stage inserts a bubble by clearing
// the control bits while the data fields hold their previous values.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_reg_write,
  input  logic        i_memto_reg,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_alu_out,
  input  logic [4:0]  i_mux,
  output logic        o_reg_write,
  output logic        o_memto_reg,
  output logic [31:0] o_rdata,
  output logic [31:0] o_alu_out,
  output logic [4:0]  o_mux
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_reg_write <= 1'b0;
      o_memto_reg <= 1'b0;
      o_rdata     <= '0;
      o_alu_out   <= '0;
      o_mux       <= '0;
    end else if (i_stall) begin
      o_reg_write <= 1'b0;
      o_memto_reg <= 1'b0;
    end else begin
      o_reg_write <= i_reg_write;
      o_memto_reg <= i_memto_reg;
      o_rdata     <= i_rdata;
      o_alu_out   <= i_alu_out;
      o_mux       <= i_mux;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: data-memory handshake FSM, upstream stall, branch/jump redirect
// and MEM/WB register. Optional access timeout enabled by MEM_TIMEOUT_EN.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_RegWrite,
  input  logic              in_MemtoReg,
  input  logic              in_MemRead,
  input  logic              in_MemWrite,
  input  logic              in_Branch,
  input  logic              in_Jump,
  input  logic [5:0]        in_opcode,
  input  logic              in_zero,
  input  logic [31:0]       in_alu_out,
  input  logic [31:0]       in_rd2,
  input  logic [4:0]        in_mux,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_jump_addr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic              pc_src_valid,
  output logic [31:0]       pc_src_target,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [31:0]       wb_rdata,
  output logic [31:0]       wb_alu_out,
  output logic [4:0]        wb_mux,
  output logic              mem_err
);

  state_e              r_state;
  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;

  logic                w_mem_op;
  logic                w_is_load;
  logic                w_timeout;
  logic                w_err;
  logic                w_taken;
  logic                w_wb_reg_write;
  logic [31:0]         w_wb_rdata;

  assign w_mem_op  = in_MemRead | in_MemWrite;
  assign w_is_load = in_MemRead & ~in_MemWrite;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_timeout = (r_state == ACCESS) && !dmem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_err     = r_err;

  // r_err is high exactly during the DONE cycle that follows an abort
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == ACCESS) ? r_cnt + 1'b1 : '0;
      r_err <= w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            r_state <= ACCESS;
            r_req   <= 1'b1;
            r_we    <= in_MemWrite;
            r_addr  <= {in_alu_out[ADDR_W-1:2], 2'b00};
            r_wdata <= in_rd2;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_rdata <= dmem_rdata;
          end else if (w_timeout) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_rdata <= ERR_DATA;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign mem_err    = w_err;

  assign mem_stall = ((r_state == IDLE) && w_mem_op) || (r_state == ACCESS);

  assign w_taken       = in_Jump | (in_Branch & branch_cond(in_opcode, in_zero));
  assign pc_src_valid  = w_taken & ~mem_stall;
  assign pc_src_target = in_Jump ? in_jump_addr : in_pc;

  // Non-loads write back zero; an aborted access always reports the error pattern
  assign w_wb_rdata     = w_err ? ERR_DATA : (w_is_load ? r_rdata : 32'h0);
  assign w_wb_reg_write = in_RegWrite & ~w_err;

  mem_wb_reg u_mem_wb_reg (
    .clk         (clk),
    .rst         (rst),
    .i_stall     (mem_stall),
    .i_reg_write (w_wb_reg_write),
    .i_memto_reg (in_MemtoReg),
    .i_rdata     (w_wb_rdata),
    .i_alu_out   (in_alu_out),
    .i_mux       (in_mux),
    .o_reg_write (wb_RegWrite),
    .o_memto_reg (wb_MemtoReg),
    .o_rdata     (wb_rdata),
    .o_alu_out   (wb_alu_out),
    .o_mux       (wb_mux)
  );

endmodule
